// File: rtl/fp16_result_stage.sv
// fp16_result_stage: registered skid-buffered output stage with result classification and saturating counters
module fp16_result_stage #(
  parameter int BITS  = 16,
  parameter int CNT_W = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [BITS-1:0]  iZ,
  output logic             oValid,
  input  logic             iReady,
  output logic [BITS-1:0]  oZ,
  output logic [4:0]       oFlags,
  input  logic             iClear,
  output logic [CNT_W-1:0] oNanCnt,
  output logic [CNT_W-1:0] oInfCnt,
  output logic [CNT_W-1:0] oSubCnt,
  output logic [CNT_W-1:0] oTotCnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  state_e state_q, state_d;
  logic [BITS+4:0] main_q, main_d, skid_q, skid_d, in_w;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic ready_q, accept, deliver;
  logic e_max, e_zero, f_zero, nan_w, inf_w, zero_w, sub_w;
  logic [3:0] hit;
  assign e_max   = iZ[14:10] == 5'h1F;
  assign e_zero  = iZ[14:10] == 5'h00;
  assign f_zero  = iZ[9:0] == 10'h000;
  assign nan_w   = e_max && !f_zero;
  assign inf_w   = e_max && f_zero;
  assign zero_w  = e_zero && f_zero;
  assign sub_w   = e_zero && !f_zero;
  assign in_w    = {iZ, iZ[15], sub_w, zero_w, inf_w, nan_w};
  assign hit     = {1'b1, sub_w, inf_w, nan_w};
  assign accept  = iValid && ready_q;
  assign deliver = (state_q != EMPTY) && iReady;
  assign oReady  = ready_q;
  assign oValid  = state_q != EMPTY;
  assign oZ      = main_q[BITS+4:5];
  assign oFlags  = main_q[4:0];
  assign oNanCnt = cnt_q[0];
  assign oInfCnt = cnt_q[1];
  assign oSubCnt = cnt_q[2];
  assign oTotCnt = cnt_q[3];
  // next state and storage moves; FULL never accepts because ready is low there
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (accept) begin
        state_d = ONE;
        main_d  = in_w;
      end
      ONE: if (accept && deliver) main_d = in_w;
        else if (accept) begin
          state_d = FULL;
          skid_d  = in_w;
        end else if (deliver) state_d = EMPTY;
      FULL: if (deliver) begin
        state_d = ONE;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  // state, buffers and the registered ready
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= state_d != FULL;
    end
  end
  // saturating event counters; clear beats a same-cycle accept
  always_comb begin
    for (int k = 0; k < 4; k++)
      cnt_d[k] = iClear ? '0 : cnt_q[k] + {{(CNT_W-1){1'b0}}, accept && hit[k] && (cnt_q[k] != '1)};
  end
  // counter registers
  always_ff @(posedge iClk) begin
    cnt_q <= iRst ? '0 : cnt_d;
  end
endmodule

// File: tb/tb_fp16_result_stage.sv
// tb_fp16_result_stage: scoreboard-driven checks of handshake, ordering, classification and counters
module tb_fp16_result_stage;
  logic clk = 0, iRst = 1, iValid = 0, iReady = 0, iClear = 0;
  logic [15:0] iZ = 0;
  logic oReady, oValid, oReady2, oValid2;
  logic [15:0] oZ, oZ2;
  logic [4:0] oFlags, oFlags2;
  logic [15:0] oNanCnt, oInfCnt, oSubCnt, oTotCnt;
  logic [1:0] nan2, inf2, sub2, tot2;
  int errors = 0, checks = 0;
  logic mon_en = 0;
  logic [20:0] sb[$];
  int occ = 0, n_deliv = 0;
  int m_nan = 0, m_inf = 0, m_sub = 0, m_tot = 0;
  logic stall = 0;
  logic [15:0] stall_z = 0;

  fp16_result_stage #(.BITS(16), .CNT_W(16)) dut (
    .iClk(clk), .iRst(iRst), .iValid(iValid), .oReady(oReady), .iZ(iZ),
    .oValid(oValid), .iReady(iReady), .oZ(oZ), .oFlags(oFlags), .iClear(iClear),
    .oNanCnt(oNanCnt), .oInfCnt(oInfCnt), .oSubCnt(oSubCnt), .oTotCnt(oTotCnt));

  fp16_result_stage #(.BITS(16), .CNT_W(2)) dut2 (
    .iClk(clk), .iRst(iRst), .iValid(iValid), .oReady(oReady2), .iZ(iZ),
    .oValid(oValid2), .iReady(iReady), .oZ(oZ2), .oFlags(oFlags2), .iClear(iClear),
    .oNanCnt(nan2), .oInfCnt(inf2), .oSubCnt(sub2), .oTotCnt(tot2));

  always #5 clk = ~clk;

  function automatic logic [4:0] cls(input logic [15:0] z);
    logic [4:0] e;
    logic [9:0] f;
    e = z[14:10];
    f = z[9:0];
    return {z[15], e == 0 && f != 0, e == 0 && f == 0, e == 31 && f == 0, e == 31 && f != 0};
  endfunction

  function automatic int sat(input int v, input logic en);
    return (en && v < 65535) ? v + 1 : v;
  endfunction

  // reference model evaluated just before each rising edge
  always @(negedge clk) begin
    if (iRst) begin
      sb.delete();
      occ = 0;
      m_nan = 0; m_inf = 0; m_sub = 0; m_tot = 0;
      stall = 0;
    end else if (mon_en) begin
      logic acc, dlv;
      logic [20:0] exp_e;
      checks++;
      if (oValid !== (occ > 0)) begin errors++; $display("FAIL mon_valid got=%b exp=%b", oValid, occ > 0); end
      checks++;
      if (oReady !== (occ < 2)) begin errors++; $display("FAIL mon_ready got=%b exp=%b", oReady, occ < 2); end
      checks++;
      if (oTotCnt !== 16'(m_tot) || oNanCnt !== 16'(m_nan) || oInfCnt !== 16'(m_inf) || oSubCnt !== 16'(m_sub)) begin
        errors++;
        $display("FAIL mon_cnt got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", oTotCnt, oNanCnt, oInfCnt, oSubCnt, m_tot, m_nan, m_inf, m_sub);
      end
      if (stall && oValid) begin
        checks++;
        if (oZ !== stall_z) begin errors++; $display("FAIL mon_stable got=%h exp=%h", oZ, stall_z); end
      end
      stall = oValid && !iReady;
      stall_z = oZ;
      dlv = oValid && iReady;
      acc = iValid && oReady;
      if (dlv) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL mon_underflow got=%h exp=none", oZ);
        end else begin
          exp_e = sb.pop_front();
          if ({oZ, oFlags} !== exp_e) begin errors++; $display("FAIL mon_data got=%h/%b exp=%h/%b", oZ, oFlags, exp_e[20:5], exp_e[4:0]); end
        end
        n_deliv++;
        occ--;
      end
      if (acc) begin
        sb.push_back({iZ, cls(iZ)});
        occ++;
      end
      if (iClear) begin
        m_nan = 0; m_inf = 0; m_sub = 0; m_tot = 0;
      end else if (acc) begin
        m_tot = sat(m_tot, 1'b1);
        m_nan = sat(m_nan, cls(iZ)[0]);
        m_inf = sat(m_inf, cls(iZ)[1]);
        m_sub = sat(m_sub, cls(iZ)[3]);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    iRst = 1;
    step();
    step();
    checks++;
    if (oValid !== 0 || oReady !== 1) begin errors++; $display("FAIL reset_hs got=%b%b exp=01", oValid, oReady); end
    checks++;
    if (oZ !== 0 || oFlags !== 0) begin errors++; $display("FAIL reset_data got=%h/%b exp=0/0", oZ, oFlags); end
    checks++;
    if (oTotCnt !== 0 || oNanCnt !== 0 || oInfCnt !== 0 || oSubCnt !== 0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", oTotCnt); end
    iRst = 0;
    mon_en = 1;
  endtask

  task automatic test_single;
    iReady = 1; iValid = 1; iZ = 16'h3C00;
    step();
    iValid = 0;
    checks++;
    if (oValid !== 1 || oZ !== 16'h3C00) begin errors++; $display("FAIL single_data got=%b/%h exp=1/3c00", oValid, oZ); end
    checks++;
    if (oFlags !== 5'b00000) begin errors++; $display("FAIL single_flags got=%b exp=00000", oFlags); end
    checks++;
    if (oTotCnt !== 1) begin errors++; $display("FAIL single_tot got=%0d exp=1", oTotCnt); end
    step();
  endtask

  task automatic test_classify;
    logic [15:0] v[5] = '{16'h7E00, 16'h7C00, 16'h8000, 16'h0001, 16'hFC00};
    logic [4:0] fl[5] = '{5'b00001, 5'b00010, 5'b10100, 5'b01000, 5'b10010};
    iClear = 1;
    step();
    iClear = 0; iReady = 1; iValid = 1; iZ = v[0];
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 4) iZ = v[i+1]; else iValid = 0;
      checks++;
      if (oZ !== v[i] || oFlags !== fl[i]) begin errors++; $display("FAIL class_%0d got=%h/%b exp=%h/%b", i, oZ, oFlags, v[i], fl[i]); end
    end
    checks++;
    if (oNanCnt !== 1 || oInfCnt !== 2 || oSubCnt !== 1 || oTotCnt !== 5) begin
      errors++;
      $display("FAIL class_cnt got=%0d/%0d/%0d/%0d exp=1/2/1/5", oNanCnt, oInfCnt, oSubCnt, oTotCnt);
    end
    step();
  endtask

  task automatic test_backpressure;
    iReady = 0; iValid = 1; iZ = 16'h1111;
    step();
    iZ = 16'h2222;
    step();
    iZ = 16'h3333;
    checks++;
    if (oReady !== 0) begin errors++; $display("FAIL bp_ready got=%b exp=0", oReady); end
    step();
    checks++;
    if (oReady !== 0 || oZ !== 16'h1111) begin errors++; $display("FAIL bp_hold got=%b/%h exp=0/1111", oReady, oZ); end
    iReady = 1;
    step();
    checks++;
    if (oValid !== 1 || oZ !== 16'h2222) begin errors++; $display("FAIL bp_d2 got=%b/%h exp=1/2222", oValid, oZ); end
    step();
    iValid = 0;
    checks++;
    if (oValid !== 1 || oZ !== 16'h3333) begin errors++; $display("FAIL bp_d3 got=%b/%h exp=1/3333", oValid, oZ); end
    step();
    checks++;
    if (oValid !== 0) begin errors++; $display("FAIL bp_empty got=%b exp=0", oValid); end
  endtask

  task automatic test_stream;
    int sent = 0;
    int base = n_deliv;
    logic acc;
    iValid = 1; iZ = 16'($urandom);
    while (sent < 1000) begin
      iReady = 1'($urandom_range(0, 1));
      acc = iValid && oReady;
      step();
      if (acc) begin
        sent++;
        iValid = $urandom_range(0, 3) != 0;
        iZ = 16'($urandom);
      end else if (!iValid) begin
        iValid = 1'($urandom_range(0, 1));
        iZ = 16'($urandom);
      end
    end
    iValid = 0; iReady = 1;
    for (int t = 0; t < 10 && sb.size() > 0; t++) step();
    checks++;
    if (sb.size() != 0 || n_deliv - base != 1000) begin
      errors++;
      $display("FAIL stream_count got=%0d left=%0d exp=1000", n_deliv - base, sb.size());
    end
  endtask

  task automatic test_sat_clear;
    iClear = 1;
    step();
    iClear = 0; iReady = 1; iValid = 1; iZ = 16'h7E01;
    repeat (5) step();
    iValid = 0;
    checks++;
    if (nan2 !== 2'd3 || tot2 !== 2'd3) begin errors++; $display("FAIL sat_nan got=%0d/%0d exp=3/3", nan2, tot2); end
    checks++;
    if (inf2 !== 0 || sub2 !== 0) begin errors++; $display("FAIL sat_other got=%0d/%0d exp=0/0", inf2, sub2); end
    checks++;
    if (oNanCnt !== 5 || oTotCnt !== 5) begin errors++; $display("FAIL sat_wide got=%0d/%0d exp=5/5", oNanCnt, oTotCnt); end
    iValid = 1; iZ = 16'h3C00; iClear = 1;
    step();
    iValid = 0; iClear = 0;
    checks++;
    if (nan2 !== 0 || tot2 !== 0 || oNanCnt !== 0 || oTotCnt !== 0 || oInfCnt !== 0 || oSubCnt !== 0) begin
      errors++;
      $display("FAIL clear_cnt got=%0d/%0d/%0d/%0d exp=0", nan2, tot2, oNanCnt, oTotCnt);
    end
    checks++;
    if (oValid !== 1 || oZ !== 16'h3C00) begin errors++; $display("FAIL clear_data got=%b/%h exp=1/3c00", oValid, oZ); end
    step();
  endtask

  task automatic test_reset_full;
    iReady = 0; iValid = 1; iZ = 16'h1234;
    step();
    iZ = 16'h5678;
    step();
    iValid = 0;
    checks++;
    if (oReady !== 0 || oTotCnt !== 2) begin errors++; $display("FAIL full_pre got=%b/%0d exp=0/2", oReady, oTotCnt); end
    iRst = 1;
    step();
    iRst = 0;
    checks++;
    if (oValid !== 0 || oReady !== 1 || oTotCnt !== 0 || oZ !== 0) begin
      errors++;
      $display("FAIL full_rst got=%b/%b/%0d/%h exp=0/1/0/0", oValid, oReady, oTotCnt, oZ);
    end
    iReady = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (oValid !== 0) begin errors++; $display("FAIL full_stale_%0d got=%b/%h exp=0", i, oValid, oZ); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_classify();
    test_backpressure();
    test_stream();
    test_sat_clear();
    test_reset_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
